// File: rtl/wb_mem_bist_master.sv
// Wishbone classic master that writes an incrementing pattern into a word RAM and reads it back.
// Optional ack timeout: define WB_BIST_TIMEOUT_EN.
module wb_mem_bist_master #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned LEN_W       = 10,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [31:0]       seed_i,
  output logic [ADDR_W-1:0] adr_o,
  output logic [31:0]       dat_o,
  input  logic [31:0]       dat_i,
  output logic              we_o,
  output logic [3:0]        sel_o,
  output logic              cyc_o,
  output logic              stb_o,
  input  logic              ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [31:0]       err_data_o,
  output logic              timeout_o
);

  typedef enum logic [2:0] {StIdle, StWr, StWgap, StRd, StRgap, StDone} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    k_q, k_d, len_q, len_d;
  logic [ADDR_W-1:0]   base_q, base_d, err_addr_q, err_addr_d;
  logic [31:0]         seed_q, seed_d, err_data_q, err_data_d;
  logic                error_q, error_d;
  logic [ADDR_W-1:0]   cur_adr;
  logic [31:0]         cur_pat;
  logic                strobe, start_ok, last_word, tmo_hit;
  logic                unused_base;

  assign unused_base = ^base_i[1:0];
  assign strobe      = (state_q == StWr) || (state_q == StRd);
  assign start_ok    = (state_q == StIdle) && start_i;
  // Word offset wraps modulo the address space.
  assign cur_adr     = base_q + ADDR_W'({k_q, 2'b00});
  assign cur_pat     = seed_q + 32'(k_q);
  assign last_word   = (k_q == len_q - LEN_W'(1));

`ifdef WB_BIST_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            timeout_q, timeout_d;

  // Counter is zero in the first strobe cycle of every transfer.
  assign tmo_hit = strobe && !ack_i && (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_cnt_d = strobe ? tmo_cnt_q + TmoW'(1) : '0;
    timeout_d = timeout_q;
    if (start_ok) timeout_d = 1'b0;
    if (tmo_hit)  timeout_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic [31:0] unused_tmo_cyc;
  assign unused_tmo_cyc = TIMEOUT_CYC;
  assign tmo_hit        = 1'b0;
  assign timeout_o      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    len_d      = len_q;
    base_d     = base_q;
    seed_d     = seed_q;
    error_d    = error_q;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d     = {base_i[ADDR_W-1:2], 2'b00};
          len_d      = len_i;
          seed_d     = seed_i;
          k_d        = '0;
          error_d    = 1'b0;
          err_addr_d = '0;
          err_data_d = '0;
          state_d    = (len_i != '0) ? StWr : StDone;
        end
      end
      StWr: begin
        if (ack_i)        state_d = StWgap;
        else if (tmo_hit) state_d = StDone;
      end
      StWgap: begin
        if (last_word) begin
          k_d     = '0;
          state_d = StRd;
        end else begin
          k_d     = k_q + LEN_W'(1);
          state_d = StWr;
        end
      end
      StRd: begin
        if (ack_i) begin
          // Only the first miscompare is recorded; the pass still runs to the end.
          if (dat_i != cur_pat) begin
            error_d = 1'b1;
            if (!error_q) begin
              err_addr_d = cur_adr;
              err_data_d = dat_i;
            end
          end
          state_d = StRgap;
        end else if (tmo_hit) begin
          state_d = StDone;
        end
      end
      StRgap: begin
        if (last_word) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + LEN_W'(1);
          state_d = StRd;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      k_q        <= '0;
      len_q      <= '0;
      base_q     <= '0;
      seed_q     <= '0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      err_data_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      len_q      <= len_d;
      base_q     <= base_d;
      seed_q     <= seed_d;
      error_q    <= error_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
    end
  end

  // Bus outputs decode the registered state, so reset clears them at the same edge.
  assign cyc_o      = strobe;
  assign stb_o      = strobe;
  assign we_o       = (state_q == StWr);
  assign sel_o      = strobe ? 4'hF : 4'h0;
  assign adr_o      = strobe ? cur_adr : '0;
  assign dat_o      = (state_q == StWr) ? cur_pat : '0;
  assign busy_o     = strobe || (state_q == StWgap) || (state_q == StRgap);
  assign done_o     = (state_q == StDone);
  assign error_o    = error_q;
  assign err_addr_o = err_addr_q;
  assign err_data_o = err_data_q;

endmodule

// File: tb/tb_wb_mem_bist_master.sv
// Bench for wb_mem_bist_master: a WB slave RAM model plus a transaction model of the test sequence.
// Define WB_BIST_TIMEOUT_EN to also exercise the ack timeout.
module tb_wb_mem_bist_master;

  typedef struct packed {
    logic        we;
    logic [10:0] adr;
    logic [31:0] dat;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] base = '0;
  logic [9:0]  len = '0;
  logic [31:0] seed = '0;
  logic [10:0] adr;
  logic [31:0] dat_o;
  logic [31:0] dat_i = '0;
  logic        we;
  logic [3:0]  sel;
  logic        cyc, stb;
  logic        ack = 1'b0;
  logic        busy, done, error, timeout;
  logic [10:0] err_addr;
  logic [31:0] err_data;

  int checks = 0;
  int errors = 0;

  // Test configuration, written only by the stimulus process.
  int          test_id = 0;
  logic [10:0] cfg_base = '0;
  logic [9:0]  cfg_len = '0;
  logic [31:0] cfg_seed = '0;
  int          slave_lat = 0;
  int          corrupt_word = -1;
  logic [31:0] corrupt_val = '0;
  int          done_at;
  bit          seen5;

  // Model and slave state, written only by the monitor process.
  int          seen_id = 0;
  xfer_t       exp_q[$];
  logic [31:0] mem [0:511];
  int          wait_cnt = 0;
  bit          prev_ack = 0, prev_wait = 0;
  logic [10:0] p_adr;
  logic [31:0] p_dat;
  logic        p_we;
  int          done_cnt = 0, stb_cycles = 0, log_n = 0;
  logic [10:0] log_adr [0:63];
  logic [31:0] log_dat [0:63];
  logic        log_we  [0:63];
  bit          model_err = 0;
  logic [10:0] model_err_addr = '0;
  logic [31:0] model_err_data = '0;

  wb_mem_bist_master dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .base_i     (base),
    .len_i      (len),
    .seed_i     (seed),
    .adr_o      (adr),
    .dat_o      (dat_o),
    .dat_i      (dat_i),
    .we_o       (we),
    .sel_o      (sel),
    .cyc_o      (cyc),
    .stb_o      (stb),
    .ack_i      (ack),
    .busy_o     (busy),
    .done_o     (done),
    .error_o    (error),
    .err_addr_o (err_addr),
    .err_data_o (err_data),
    .timeout_o  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // Monitor: builds the expected transfer list from the test rules, plays the slave, checks
  // protocol every cycle and each acknowledged transfer against the list.
  always @(negedge clk) begin : mon
    xfer_t       e;
    logic [10:0] b_al;
    logic [31:0] rdat;
    if (test_id != seen_id) begin
      seen_id = test_id;
      exp_q.delete();
      done_cnt = 0; stb_cycles = 0; log_n = 0;
      model_err = 0; model_err_addr = '0; model_err_data = '0;
      b_al = {cfg_base[10:2], 2'b00};
      for (int k = 0; k < int'(cfg_len); k++) begin
        e.we = 1'b1; e.adr = 11'(int'(b_al) + 4 * k); e.dat = cfg_seed + 32'(k);
        exp_q.push_back(e);
      end
      for (int k = 0; k < int'(cfg_len); k++) begin
        e.we = 1'b0; e.adr = 11'(int'(b_al) + 4 * k); e.dat = cfg_seed + 32'(k);
        exp_q.push_back(e);
      end
    end
    if (rst) begin
      ack = 1'b0; wait_cnt = 0; prev_ack = 0; prev_wait = 0;
    end else begin
      chk("stb_eq_cyc", 64'(stb), 64'(cyc));
      chk("sel", 64'(sel), stb ? 64'hF : 64'h0);
      if (stb) chk("busy_in_xfer", 64'(busy), 64'd1);
      if (done) begin
        done_cnt++;
        chk("busy_at_done", 64'(busy), 64'd0);
      end
      if (prev_ack) chk("gap", 64'(stb), 64'd0);
      if (prev_wait) begin
        chk("hold_stb", 64'(stb), 64'd1);
        chk("hold_adr", 64'(adr), 64'(p_adr));
        chk("hold_we", 64'(we), 64'(p_we));
        chk("hold_dat", 64'(dat_o), 64'(p_dat));
      end
      prev_ack = 0; prev_wait = 0;
      if (stb) begin
        stb_cycles++;
        if (wait_cnt >= slave_lat) begin
          ack = 1'b1; wait_cnt = 0; prev_ack = 1;
          rdat = '0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_xfer actual adr=0x%0h we=%0d required none", adr, we);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_we", 64'(we), 64'(e.we));
            chk("xfer_adr", 64'(adr), 64'(e.adr));
            if (e.we) begin
              chk("xfer_wdat", 64'(dat_o), 64'(e.dat));
              mem[adr[10:2]] = dat_o;
            end else begin
              rdat = (int'(adr[10:2]) == corrupt_word) ? corrupt_val : mem[adr[10:2]];
              if (rdat != e.dat && !model_err) begin
                model_err = 1; model_err_addr = e.adr; model_err_data = rdat;
              end
            end
          end
          dat_i = rdat;
          if (log_n < 64) begin
            log_adr[log_n] = adr; log_we[log_n] = we;
            log_dat[log_n] = we ? dat_o : rdat;
          end
          log_n++;
        end else begin
          ack = 1'b0; wait_cnt++; prev_wait = 1;
          p_adr = adr; p_dat = dat_o; p_we = we;
        end
      end else begin
        ack = 1'b0; wait_cnt = 0;
      end
    end
  end

  task automatic run_test(input string nm, input logic [10:0] b, input logic [9:0] l,
                          input logic [31:0] s, input int lat, input int bad_word,
                          input logic [31:0] bad_val, input bit poke, input bit exp_tmo);
    bit seen;
    seen = 0; done_at = -1;
    cfg_base = b; cfg_len = l; cfg_seed = s;
    slave_lat = lat; corrupt_word = bad_word; corrupt_val = bad_val;
    test_id++;
    @(posedge clk); #1;
    base = b; len = l; seed = s; start = 1'b1;
    @(posedge clk); #1;
    // Scramble the inputs: the run must use the captured values.
    start = 1'b0; base = 11'($urandom); len = 10'($urandom); seed = $urandom;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk({nm, "_stb_next"}, 64'(stb), 64'(l != 0));
        chk({nm, "_busy_next"}, 64'(busy), 64'(l != 0));
        chk({nm, "_err_clr"}, 64'(error), 64'd0);
      end
      if (poke && i == 2) start = 1'b1;
      if (poke && i == 3) start = 1'b0;
      if (done) begin
        seen = 1; done_at = i;
      end
    end
    start = 1'b0;
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({nm, "_busy_end"}, 64'(busy), 64'd0);
    if (exp_tmo) begin
      chk({nm, "_timeout"}, 64'(timeout), 64'd1);
      chk({nm, "_stb_cycles"}, 64'(stb_cycles), 64'd16);
    end else begin
      chk({nm, "_left"}, 64'(exp_q.size()), 64'd0);
      chk({nm, "_timeout"}, 64'(timeout), 64'd0);
      chk({nm, "_error"}, 64'(error), 64'(model_err));
      chk({nm, "_err_addr"}, 64'(err_addr), 64'(model_err_addr));
      chk({nm, "_err_data"}, 64'(err_data), 64'(model_err_data));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc", 64'(cyc), 64'd0);
    chk("rst_stb", 64'(stb), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    chk("rst_adr", 64'(adr), 64'd0);
    chk("rst_dat", 64'(dat_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    chk("rst_err_data", 64'(err_data), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Ideal slave with one wait state: 3 cycles per word, start poked while busy.
    run_test("t1", 11'h000, 10'd4, 32'h1000, 1, -1, 32'h0, 1, 0);
    chk("t1_done_at", 64'(done_at), 64'd24);
    chk("t1_nxfer", 64'(log_n), 64'd8);
    chk("t1_w0_adr", 64'(log_adr[0]), 64'h000);
    chk("t1_w0_dat", 64'(log_dat[0]), 64'h1000);
    chk("t1_w3_adr", 64'(log_adr[3]), 64'h00C);
    chk("t1_w3_dat", 64'(log_dat[3]), 64'h1003);
    chk("t1_r0_we", 64'(log_we[4]), 64'd0);
    chk("t1_error", 64'(error), 64'd0);

    // Word 2 reads back corrupted.
    run_test("t2", 11'h000, 10'd4, 32'h1000, 0, 2, 32'h0000DEAD, 0, 0);
    chk("t2_error", 64'(error), 64'd1);
    chk("t2_err_addr", 64'(err_addr), 64'h008);
    chk("t2_err_data", 64'(err_data), 64'h0000DEAD);
    chk("t2_nxfer", 64'(log_n), 64'd8);

    // Reset while a write strobe is waiting for ack.
    cfg_base = 11'h040; cfg_len = 10'd3; cfg_seed = 32'h55; slave_lat = 3; corrupt_word = -1;
    test_id++;
    @(posedge clk); #1;
    base = 11'h040; len = 10'd3; seed = 32'h55; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen5 = 0;
    for (int i = 0; i < 10 && !seen5; i++) begin
      @(negedge clk);
      if (stb) seen5 = 1;
    end
    chk("t5_stb_seen", 64'(seen5), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_cyc", 64'(cyc), 64'd0);
    chk("t5_stb", 64'(stb), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    run_test("t5_clean", 11'h040, 10'd3, 32'h55, 0, -1, 32'h0, 0, 0);

    // Address wrap and pattern wrap, unaligned base bits ignored.
    run_test("t3", 11'h7FE, 10'd2, 32'hFFFF_FFFF, 2, -1, 32'h0, 0, 0);
    chk("t3_w0_adr", 64'(log_adr[0]), 64'h7FC);
    chk("t3_w0_dat", 64'(log_dat[0]), 64'hFFFF_FFFF);
    chk("t3_w1_adr", 64'(log_adr[1]), 64'h000);
    chk("t3_w1_dat", 64'(log_dat[1]), 64'h0);
    chk("t3_r0_adr", 64'(log_adr[2]), 64'h7FC);

    // Zero-length test: no bus cycles, done in the cycle after the start edge.
    run_test("t4", 11'h123, 10'd0, 32'h5, 0, -1, 32'h0, 0, 0);
    chk("t4_done_at", 64'(done_at), 64'd0);
    chk("t4_stb_cycles", 64'(stb_cycles), 64'd0);

`ifdef WB_BIST_TIMEOUT_EN
    run_test("t6", 11'h100, 10'd4, 32'h0, 100000, -1, 32'h0, 0, 1);
    chk("t6_done_at", 64'(done_at), 64'd16);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
